uart_mcb_bridge: RTL and testbench

- Byte-command bridge between a UART byte stream and one Spartan-6 MCB user port (port 0), with parametrised data width and maximum burst length.
- Sits between the UART rx/tx byte engines and the MIG user port inside the UART-to-DDR3 test top.
- Lets a host PC write and read DDR3 bursts using a fixed binary frame format.

---
 rtl/uart_mcb_bridge.sv | 213 +++++++++++++++++++++
 tb/tb_uart_mcb_bridge.sv | 464 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_mcb_bridge.sv
// uart_mcb_bridge: binary byte-frame bridge from a UART byte stream to one MCB user port.
// Rev 1.0 - initial release.
`default_nettype none

module uart_mcb_bridge #(
  parameter int DATA_WIDTH     = 128,
  parameter int ADDR_WIDTH     = 30,
  parameter int MAX_BL         = 64,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                       sys_clk_i,
  input  logic                       sys_rst_i,
  input  logic                       calib_done_i,
  input  logic                       rx_valid_i,
  input  logic [7:0]                 rx_data_i,
  output logic                       tx_valid_o,
  output logic [7:0]                 tx_data_o,
  input  logic                       tx_ready_i,
  output logic                       p0_cmd_en_o,
  output logic [2:0]                 p0_cmd_instr_o,
  output logic [5:0]                 p0_cmd_bl_o,
  output logic [ADDR_WIDTH-1:0]      p0_cmd_byte_addr_o,
  input  logic                       p0_cmd_full_i,
  output logic                       p0_wr_en_o,
  output logic [DATA_WIDTH-1:0]      p0_wr_data_o,
  output logic [DATA_WIDTH/8-1:0]    p0_wr_mask_o,
  input  logic                       p0_wr_full_i,
  output logic                       p0_rd_en_o,
  input  logic [DATA_WIDTH-1:0]      p0_rd_data_i,
  input  logic                       p0_rd_empty_i,
  output logic                       busy_o,
  output logic                       err_o
);

  localparam int DATA_BYTES = DATA_WIDTH / 8;
  localparam int OFS        = $clog2(DATA_BYTES);
  localparam int TW         = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [ADDR_WIDTH-1:0] c_ALIGN_MASK = {{(ADDR_WIDTH-OFS){1'b1}}, {OFS{1'b0}}};
  localparam logic [OFS-1:0]        c_LAST_BYTE  = OFS'(DATA_BYTES - 1);
  localparam logic [TW-1:0]         c_TMO_LAST   = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] c_IDLE  = 3'd0;
  localparam logic [2:0] c_HDR   = 3'd1;
  localparam logic [2:0] c_WDATA = 3'd2;
  localparam logic [2:0] c_CMD   = 3'd3;
  localparam logic [2:0] c_ACK   = 3'd4;
  localparam logic [2:0] c_RDATA = 3'd5;
  localparam logic [2:0] c_TXB   = 3'd6;
  localparam logic [2:0] c_ERR   = 3'd7;

  logic [2:0]            r_state;
  logic [2:0]            r_instr;
  logic [2:0]            r_hdr_cnt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [5:0]            r_bl;
  logic [5:0]            r_word_cnt;
  logic [OFS-1:0]        r_byte_cnt;
  logic [DATA_WIDTH-1:0] r_word;
  logic [TW-1:0]         r_timer;
  logic                  r_wr_en;
  logic                  r_tx_valid;
  logic [7:0]            r_tx_data;
  logic                  r_err;

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      r_state    <= c_IDLE;
      r_instr    <= 3'b000;
      r_hdr_cnt  <= '0;
      r_addr     <= '0;
      r_bl       <= '0;
      r_word_cnt <= '0;
      r_byte_cnt <= '0;
      r_word     <= '0;
      r_timer    <= '0;
      r_wr_en    <= 1'b0;
      r_tx_valid <= 1'b0;
      r_tx_data  <= 8'h00;
      r_err      <= 1'b0;
    end else begin
      r_wr_en <= 1'b0;
      if (r_wr_en && p0_wr_full_i) r_err <= 1'b1;
      case (r_state)
        c_IDLE: begin
          if (rx_valid_i && calib_done_i) begin
            r_hdr_cnt <= '0;
            r_timer   <= '0;
            if (rx_data_i == 8'h57) begin
              r_instr <= 3'b000;
              r_state <= c_HDR;
            end else if (rx_data_i == 8'h52) begin
              r_instr <= 3'b001;
              r_state <= c_HDR;
            end else begin
              r_tx_valid <= 1'b1;
              r_tx_data  <= 8'h45;
              r_err      <= 1'b1;
              r_state    <= c_ERR;
            end
          end
        end
        c_HDR: begin
          if (rx_valid_i) begin
            r_timer <= '0;
            if (r_hdr_cnt == 3'd4) begin
              r_bl       <= (rx_data_i > 8'(MAX_BL - 1)) ? 6'(MAX_BL - 1) : rx_data_i[5:0];
              r_byte_cnt <= '0;
              r_word_cnt <= '0;
              r_state    <= r_instr[0] ? c_CMD : c_WDATA;
            end else begin
              r_addr    <= {r_addr[ADDR_WIDTH-9:0], rx_data_i};
              r_hdr_cnt <= r_hdr_cnt + 3'd1;
            end
          end else if (r_timer == c_TMO_LAST) begin
            r_tx_valid <= 1'b1;
            r_tx_data  <= 8'h45;
            r_err      <= 1'b1;
            r_state    <= c_ERR;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        c_WDATA: begin
          // First byte of a word is shifted in at the top and ends up in bits [7:0].
          if (rx_valid_i) begin
            r_timer <= '0;
            r_word  <= {rx_data_i, r_word[DATA_WIDTH-1:8]};
            if (r_byte_cnt == c_LAST_BYTE) begin
              r_byte_cnt <= '0;
              r_wr_en    <= 1'b1;
            end else begin
              r_byte_cnt <= r_byte_cnt + OFS'(1);
            end
          end else if (r_timer == c_TMO_LAST) begin
            r_tx_valid <= 1'b1;
            r_tx_data  <= 8'h45;
            r_err      <= 1'b1;
            r_state    <= c_ERR;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
          // Leave only after the final push so data always precedes the command.
          if (r_wr_en) begin
            if (r_word_cnt == r_bl) r_state <= c_CMD;
            else                    r_word_cnt <= r_word_cnt + 6'd1;
          end
        end
        c_CMD: begin
          if (!p0_cmd_full_i) begin
            if (r_instr[0]) begin
              r_state <= c_RDATA;
            end else begin
              r_tx_valid <= 1'b1;
              r_tx_data  <= 8'h4B;
              r_state    <= c_ACK;
            end
          end
        end
        c_ACK, c_ERR: begin
          if (r_tx_valid && tx_ready_i) begin
            r_tx_valid <= 1'b0;
            r_state    <= c_IDLE;
          end
        end
        c_RDATA: begin
          if (!p0_rd_empty_i) begin
            r_word     <= p0_rd_data_i;
            r_tx_data  <= p0_rd_data_i[7:0];
            r_tx_valid <= 1'b1;
            r_byte_cnt <= '0;
            r_state    <= c_TXB;
          end
        end
        c_TXB: begin
          if (tx_ready_i) begin
            if (r_byte_cnt == c_LAST_BYTE) begin
              r_tx_valid <= 1'b0;
              r_byte_cnt <= '0;
              if (r_word_cnt == r_bl) begin
                r_state <= c_IDLE;
              end else begin
                r_word_cnt <= r_word_cnt + 6'd1;
                r_state    <= c_RDATA;
              end
            end else begin
              r_tx_data  <= r_word[15:8];
              r_word     <= {8'h00, r_word[DATA_WIDTH-1:8]};
              r_byte_cnt <= r_byte_cnt + OFS'(1);
            end
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  assign p0_cmd_en_o        = (r_state == c_CMD) && !p0_cmd_full_i;
  assign p0_rd_en_o         = (r_state == c_RDATA) && !p0_rd_empty_i;
  assign p0_cmd_instr_o     = r_instr;
  assign p0_cmd_bl_o        = r_bl;
  assign p0_cmd_byte_addr_o = r_addr & c_ALIGN_MASK;
  assign p0_wr_en_o         = r_wr_en;
  assign p0_wr_data_o       = r_word;
  assign p0_wr_mask_o       = '0;
  assign tx_valid_o         = r_tx_valid;
  assign tx_data_o          = r_tx_data;
  assign busy_o             = (r_state != c_IDLE);
  assign err_o              = r_err;

endmodule

`default_nettype wire

// File: tb/tb_uart_mcb_bridge.sv
// tb_uart_mcb_bridge: scoreboard bench for uart_mcb_bridge (MCB port and UART byte models).
`default_nettype none

module tb_uart_mcb_bridge;
  localparam int DW = 128;
  localparam int DB = DW / 8;
  localparam int AW = 30;
  localparam int TO = 200;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          calib = 1'b0;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          tx_ready = 1'b1;
  logic          cmd_full = 1'b0;
  logic          wr_full = 1'b0;
  logic          rd_empty = 1'b1;
  logic [DW-1:0] rd_data = '0;

  logic          tx_valid_o;
  logic [7:0]    tx_data_o;
  logic          p0_cmd_en_o;
  logic [2:0]    p0_cmd_instr_o;
  logic [5:0]    p0_cmd_bl_o;
  logic [AW-1:0] p0_cmd_byte_addr_o;
  logic          p0_wr_en_o;
  logic [DW-1:0] p0_wr_data_o;
  logic [DB-1:0] p0_wr_mask_o;
  logic          p0_rd_en_o;
  logic          busy_o;
  logic          err_o;

  uart_mcb_bridge #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_BL(64), .TIMEOUT_CYCLES(TO)) dut (
    .sys_clk_i(clk), .sys_rst_i(rst), .calib_done_i(calib),
    .rx_valid_i(rx_valid), .rx_data_i(rx_data),
    .tx_valid_o(tx_valid_o), .tx_data_o(tx_data_o), .tx_ready_i(tx_ready),
    .p0_cmd_en_o(p0_cmd_en_o), .p0_cmd_instr_o(p0_cmd_instr_o), .p0_cmd_bl_o(p0_cmd_bl_o),
    .p0_cmd_byte_addr_o(p0_cmd_byte_addr_o), .p0_cmd_full_i(cmd_full),
    .p0_wr_en_o(p0_wr_en_o), .p0_wr_data_o(p0_wr_data_o), .p0_wr_mask_o(p0_wr_mask_o),
    .p0_wr_full_i(wr_full),
    .p0_rd_en_o(p0_rd_en_o), .p0_rd_data_i(rd_data), .p0_rd_empty_i(rd_empty),
    .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  logic [7:0]    exp_tx[$];
  logic [DW-1:0] exp_wr[$];
  logic [38:0]   exp_cmd[$];
  logic [DW-1:0] rdq[$];

  int n_cmp = 0, n_err = 0;
  int n_tx = 0, n_cmd = 0, n_rd = 0, n_wr = 0;
  bit pop_pend = 1'b0;
  bit hold = 1'b0;
  logic [7:0]    hold_data;
  logic [7:0]    m_tx_e;
  logic [DW-1:0] m_wr_e;
  logic [38:0]   m_cmd_e;

  // Write-data port monitor
  always @(negedge clk) begin
    if (p0_wr_en_o) begin
      n_wr++;
      n_cmp++;
      if (exp_wr.size() == 0) begin
        n_err++;
        $display("FAIL wr_push: unexpected push data=%h", p0_wr_data_o);
      end else begin
        m_wr_e = exp_wr.pop_front();
        if (p0_wr_data_o !== m_wr_e || p0_wr_mask_o !== '0) begin
          n_err++;
          $display("FAIL wr_push: got data=%h mask=%h, expected data=%h mask=0", p0_wr_data_o, p0_wr_mask_o, m_wr_e);
        end
      end
    end
  end

  // Command port monitor
  always @(negedge clk) begin
    if (p0_cmd_en_o) begin
      n_cmd++;
      n_cmp++;
      if (exp_cmd.size() == 0) begin
        n_err++;
        $display("FAIL cmd_push: unexpected command instr=%b bl=%0d addr=%h", p0_cmd_instr_o, p0_cmd_bl_o, p0_cmd_byte_addr_o);
      end else begin
        m_cmd_e = exp_cmd.pop_front();
        if ({p0_cmd_instr_o, p0_cmd_bl_o, p0_cmd_byte_addr_o} !== m_cmd_e) begin
          n_err++;
          $display("FAIL cmd_push: got instr=%b bl=%0d addr=%h, expected instr=%b bl=%0d addr=%h",
                   p0_cmd_instr_o, p0_cmd_bl_o, p0_cmd_byte_addr_o, m_cmd_e[38:36], m_cmd_e[35:30], m_cmd_e[29:0]);
        end
      end
    end
  end

  // UART transmitter model: handshakes, plus hold-stability of stalled bytes
  always @(negedge clk) begin
    if (tx_valid_o) begin
      if (hold) begin
        n_cmp++;
        if (tx_data_o !== hold_data) begin
          n_err++;
          $display("FAIL tx_stable: got %h while stalled, expected %h", tx_data_o, hold_data);
        end
      end
      if (tx_ready) begin
        hold = 1'b0;
        n_tx++;
        n_cmp++;
        if (exp_tx.size() == 0) begin
          n_err++;
          $display("FAIL tx_byte: unexpected byte %h", tx_data_o);
        end else begin
          m_tx_e = exp_tx.pop_front();
          if (tx_data_o !== m_tx_e) begin
            n_err++;
            $display("FAIL tx_byte: got %h expected %h", tx_data_o, m_tx_e);
          end
        end
      end else begin
        hold = 1'b1;
        hold_data = tx_data_o;
      end
    end else begin
      if (hold && !rst) begin
        n_cmp++;
        n_err++;
        $display("FAIL tx_hold: tx_valid dropped to %b before handshake, expected 1", tx_valid_o);
      end
      hold = 1'b0;
    end
  end

  // MCB read FIFO model
  always @(negedge clk) begin
    if (p0_rd_en_o) begin
      n_rd++;
      n_cmp++;
      if (rdq.size() == 0) begin
        n_err++;
        $display("FAIL rd_pop: pop with model FIFO empty, got rd_en=%b expected 0", p0_rd_en_o);
      end
      pop_pend = 1'b1;
    end
  end

  always @(posedge clk) begin
    #1;
    if (pop_pend && rdq.size() > 0) void'(rdq.pop_front());
    pop_pend = 1'b0;
    rd_empty = (rdq.size() == 0);
    rd_data  = rd_empty ? '0 : rdq[0];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    tick();
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
    tick();
  endtask

  task automatic send_hdr(input logic [7:0] op, input logic [31:0] a, input logic [7:0] bl);
    send_byte(op);
    send_byte(a[31:24]);
    send_byte(a[23:16]);
    send_byte(a[15:8]);
    send_byte(a[7:0]);
    send_byte(bl);
  endtask

  task automatic send_word(input logic [DW-1:0] w);
    for (int i = 0; i < DB; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic expect_word_tx(input logic [DW-1:0] w);
    for (int i = 0; i < DB; i++) exp_tx.push_back(w[8*i +: 8]);
  endtask

  function automatic logic [38:0] mk_cmd(input logic [2:0] ins, input logic [7:0] bl, input logic [31:0] a);
    logic [5:0] b;
    b = (bl > 8'd63) ? 6'd63 : bl[5:0];
    return {ins, b, a[29:0] & 30'h3FFFFFF0};
  endfunction

  function automatic logic [DW-1:0] rnd_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic wait_done(input int budget, output bit ok);
    int c;
    c = 0;
    while ((busy_o || exp_tx.size() != 0 || exp_wr.size() != 0 || exp_cmd.size() != 0) && c < budget) begin
      tick();
      c++;
    end
    ok = (c < budget);
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    n_cmp++;
    if ({tx_valid_o, p0_cmd_en_o, p0_wr_en_o, p0_rd_en_o, busy_o, err_o} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: got %b expected 000000", {tx_valid_o, p0_cmd_en_o, p0_wr_en_o, p0_rd_en_o, busy_o, err_o});
    end
    n_cmp++;
    if (tx_data_o !== 8'h00) begin
      n_err++;
      $display("FAIL reset_txdata: got %h expected 00", tx_data_o);
    end
    n_cmp++;
    if ({p0_cmd_instr_o, p0_cmd_bl_o, p0_cmd_byte_addr_o} !== 39'd0 || p0_wr_data_o !== '0 || p0_wr_mask_o !== '0) begin
      n_err++;
      $display("FAIL reset_port: got instr=%b bl=%0d addr=%h wdata=%h expected all 0", p0_cmd_instr_o, p0_cmd_bl_o, p0_cmd_byte_addr_o, p0_wr_data_o);
    end
    rst = 1'b0;
    calib = 1'b1;
    tick();
  endtask

  task automatic test_write();
    logic [DW-1:0] w;
    bit ok;
    for (int i = 0; i < DB; i++) w[8*i +: 8] = 8'(i);
    exp_wr.push_back(w);
    exp_cmd.push_back(mk_cmd(3'b000, 8'd0, 32'h0000_0100));
    exp_tx.push_back(8'h4B);
    send_hdr(8'h57, 32'h0000_0100, 8'd0);
    send_word(w);
    wait_done(500, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL write_done: got still-busy expected frame complete"); end
    n_cmp++;
    if (err_o !== 1'b0) begin n_err++; $display("FAIL write_err: got %b expected 0", err_o); end
  endtask

  task automatic test_read();
    logic [DW-1:0] a, b;
    int rd0;
    bit ok;
    a = rnd_word();
    b = rnd_word();
    rd0 = n_rd;
    rdq.push_back(a);
    rdq.push_back(b);
    exp_cmd.push_back(mk_cmd(3'b001, 8'd1, 32'h0000_0100));
    expect_word_tx(a);
    expect_word_tx(b);
    send_hdr(8'h52, 32'h0000_0100, 8'd1);
    wait_done(500, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL read_done: got still-busy expected frame complete"); end
    n_cmp++;
    if (n_rd - rd0 !== 2) begin n_err++; $display("FAIL read_pops: got %0d expected 2", n_rd - rd0); end
  endtask

  task automatic test_calib_err();
    bit ok;
    calib = 1'b0;
    send_byte(8'h57);
    n_cmp++;
    if (busy_o !== 1'b0) begin n_err++; $display("FAIL uncalib_busy: got %b expected 0", busy_o); end
    calib = 1'b1;
    exp_tx.push_back(8'h45);
    send_byte(8'h33);
    wait_done(100, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL badop_done: got still-busy expected idle"); end
    n_cmp++;
    if (err_o !== 1'b1) begin n_err++; $display("FAIL badop_err: got %b expected 1", err_o); end
  endtask

  task automatic test_timeout();
    logic [DW-1:0] c;
    int cmd0, wr0;
    bit ok;
    cmd0 = n_cmd;
    wr0  = n_wr;
    exp_tx.push_back(8'h45);
    send_hdr(8'h57, 32'h0000_0400, 8'd0);
    send_byte(8'hA1);
    send_byte(8'hA2);
    send_byte(8'hA3);
    wait_done(TO + 100, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL timeout_done: got still-busy expected idle after timeout"); end
    n_cmp++;
    if (n_cmd !== cmd0 || n_wr !== wr0) begin
      n_err++;
      $display("FAIL timeout_nocmd: got %0d cmds %0d pushes expected 0 0", n_cmd - cmd0, n_wr - wr0);
    end
    c = rnd_word();
    rdq.push_back(c);
    exp_cmd.push_back(mk_cmd(3'b001, 8'd0, 32'h0000_0500));
    expect_word_tx(c);
    send_hdr(8'h52, 32'h0000_0500, 8'd0);
    wait_done(300, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL post_timeout_read: got still-busy expected complete"); end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] w, d;
    int cmd0, tx0, c;
    bit ok;
    w = rnd_word();
    cmd0 = n_cmd;
    cmd_full = 1'b1;
    exp_wr.push_back(w);
    exp_cmd.push_back(mk_cmd(3'b000, 8'd0, 32'h0000_0300));
    exp_tx.push_back(8'h4B);
    send_hdr(8'h57, 32'h0000_0300, 8'd0);
    send_word(w);
    repeat (10) tick();
    n_cmp++;
    if (n_cmd !== cmd0 || busy_o !== 1'b1) begin
      n_err++;
      $display("FAIL cmd_full_hold: got %0d cmds busy=%b expected 0 cmds busy=1", n_cmd - cmd0, busy_o);
    end
    cmd_full = 1'b0;
    wait_done(100, ok);
    n_cmp++;
    if (!ok || n_cmd - cmd0 !== 1) begin
      n_err++;
      $display("FAIL cmd_full_release: got %0d cmds ok=%b expected 1 cmd", n_cmd - cmd0, ok);
    end
    tx_ready = 1'b0;
    d = rnd_word();
    rdq.push_back(d);
    exp_cmd.push_back(mk_cmd(3'b001, 8'd0, 32'h0000_0310));
    expect_word_tx(d);
    send_hdr(8'h52, 32'h0000_0310, 8'd0);
    c = 0;
    while (!tx_valid_o && c < 50) begin tick(); c++; end
    tx0 = n_tx;
    repeat (5) tick();
    n_cmp++;
    if (tx_valid_o !== 1'b1 || tx_data_o !== d[7:0] || n_tx !== tx0) begin
      n_err++;
      $display("FAIL tx_stall: got valid=%b data=%h sent=%0d expected valid=1 data=%h sent=0", tx_valid_o, tx_data_o, n_tx - tx0, d[7:0]);
    end
    tx_ready = 1'b1;
    wait_done(200, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL tx_stall_done: got still-busy expected complete"); end
  endtask

  task automatic test_bl_clamp();
    logic [DW-1:0] w;
    int rd0;
    bit ok;
    rd0 = n_rd;
    for (int i = 0; i < 64; i++) begin
      w = rnd_word();
      rdq.push_back(w);
      expect_word_tx(w);
    end
    exp_cmd.push_back(mk_cmd(3'b001, 8'h80, 32'hFFFF_FFFF));
    send_hdr(8'h52, 32'hFFFF_FFFF, 8'h80);
    wait_done(5000, ok);
    n_cmp++;
    if (!ok || n_rd - rd0 !== 64) begin
      n_err++;
      $display("FAIL bl_clamp: got %0d pops ok=%b expected 64", n_rd - rd0, ok);
    end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] w;
    int tx0, c;
    bit ok;
    tx0 = n_tx;
    for (int i = 0; i < 4; i++) begin
      w = rnd_word();
      rdq.push_back(w);
      expect_word_tx(w);
    end
    exp_cmd.push_back(mk_cmd(3'b001, 8'd3, 32'h0000_0600));
    send_hdr(8'h52, 32'h0000_0600, 8'd3);
    c = 0;
    while (n_tx - tx0 < 20 && c < 500) begin tick(); c++; end
    rst = 1'b1;
    tick();
    n_cmp++;
    if ({tx_valid_o, p0_cmd_en_o, p0_wr_en_o, p0_rd_en_o, busy_o, err_o, tx_data_o} !== 14'd0) begin
      n_err++;
      $display("FAIL midreset_out: got valid=%b cmd=%b wr=%b rd=%b busy=%b err=%b data=%h expected all 0",
               tx_valid_o, p0_cmd_en_o, p0_wr_en_o, p0_rd_en_o, busy_o, err_o, tx_data_o);
    end
    tick();
    rst = 1'b0;
    exp_tx.delete();
    rdq.delete();
    tick();
    w = rnd_word();
    exp_wr.push_back(w);
    exp_cmd.push_back(mk_cmd(3'b000, 8'd0, 32'h0000_0700));
    exp_tx.push_back(8'h4B);
    send_hdr(8'h57, 32'h0000_0700, 8'd0);
    send_word(w);
    wait_done(300, ok);
    n_cmp++;
    if (!ok || err_o !== 1'b0) begin
      n_err++;
      $display("FAIL post_reset_write: got ok=%b err=%b expected ok=1 err=0", ok, err_o);
    end
  endtask

  task automatic test_wr_full();
    logic [DW-1:0] w;
    int wr0;
    bit ok;
    wr0 = n_wr;
    w = rnd_word();
    wr_full = 1'b1;
    exp_wr.push_back(w);
    exp_cmd.push_back(mk_cmd(3'b000, 8'd0, 32'h0000_0800));
    exp_tx.push_back(8'h4B);
    send_hdr(8'h57, 32'h0000_0800, 8'd0);
    send_word(w);
    wait_done(300, ok);
    wr_full = 1'b0;
    n_cmp++;
    if (!ok || err_o !== 1'b1 || n_wr - wr0 !== 1) begin
      n_err++;
      $display("FAIL wr_full: got ok=%b err=%b pushes=%0d expected ok=1 err=1 pushes=1", ok, err_o, n_wr - wr0);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_calib_err();
    test_timeout();
    test_backpressure();
    test_bl_clamp();
    test_reset_mid();
    test_wr_full();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
